// File: rtl/replicate_pack_arbiter.sv
// ---------------------------------------------------------------------------
// replicate_pack_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer for a shared replicate-and-concatenate
//   packing datapath. Three requesters each offer one bit, selected from a
//   source word by an index. The bit from the granted requester is replicated
//   by a fixed factor and shifted into an accumulator. Requester 0 uses a
//   factor of 1, requester 1 uses 8 and requester 2 uses 16. The accumulator
//   is emitted as one word when it holds exactly WIDTH bits, or earlier on a
//   flush. A flushed word is zero-padded in the LSBs. The first-accepted item
//   always lands in the MSBs of the emitted word.
//
// Optional feature:
//   REPLICATE_PACK_ARBITER_WORD_COUNT_EN adds the o_word_count output. It
//   counts output handshakes, flushed words included, and wraps at 16 bits.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_valid[2:0]    per-requester request
//   o_ready[2:0]    per-requester grant (one-hot or zero)
//   i_data0..2      source words, one per requester
//   i_idx0..2       bit index into the matching source word
//   i_flush         emit the partial word
//   o_valid         output word available
//   i_ready         downstream accepts the output word
//   o_data          accumulator contents (first item in the MSBs)
//   o_fill          accumulator fill count, in bits
//   o_word_count    (optional) number of words handed downstream
//   o_dbg_state     FSM state: 0 = COLLECT, 1 = EMIT
//
// Handshake:
//   Input side: an item from requester k is accepted in a cycle where both
//   i_valid[k] and o_ready[k] are 1. o_ready is combinational from i_valid,
//   so producers must not make i_valid depend on o_ready.
//   Output side: a word transfers in a cycle where both o_valid and i_ready
//   are 1. While o_valid is 1 and i_ready is 0, o_data and o_fill are held.
// ---------------------------------------------------------------------------
module replicate_pack_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [2:0]                 i_valid,
  output logic [2:0]                 o_ready,
  input  logic [WIDTH-1:0]           i_data0,
  input  logic [WIDTH-1:0]           i_data1,
  input  logic [WIDTH-1:0]           i_data2,
  input  logic [$clog2(WIDTH)-1:0]   i_idx0,
  input  logic [$clog2(WIDTH)-1:0]   i_idx1,
  input  logic [$clog2(WIDTH)-1:0]   i_idx2,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(WIDTH):0]     o_fill,
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
  output logic [15:0]                o_word_count,
`endif
  output logic                       o_dbg_state
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  // The sums below carry one extra bit. cnt + 16 can exceed WIDTH, and the
  // fit test must see that overflow rather than a wrapped value.
  localparam logic [CW:0]   WIDTH_W = (CW+1)'(WIDTH);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW:0]   REP0    = (CW+1)'(1);
  localparam logic [CW:0]   REP1    = (CW+1)'(8);
  localparam logic [CW:0]   REP2    = (CW+1)'(16);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       ptr, ptr_n;

  logic             b0, b1, b2;
  logic [CW:0]      sum0, sum1, sum2;
  logic [2:0]       elig;
  logic             flush_take;
  logic             gnt_any;
  logic [1:0]       gnt_sel;
  logic [CW-1:0]    pad_shift;

  // Selected bits and per-requester fit checks.
  assign b0   = i_data0[i_idx0];
  assign b1   = i_data1[i_idx1];
  assign b2   = i_data2[i_idx2];

  assign sum0 = {1'b0, cnt} + REP0;
  assign sum1 = {1'b0, cnt} + REP1;
  assign sum2 = {1'b0, cnt} + REP2;

  assign elig[0] = i_valid[0] && (sum0 <= WIDTH_W);
  assign elig[1] = i_valid[1] && (sum1 <= WIDTH_W);
  assign elig[2] = i_valid[2] && (sum2 <= WIDTH_W);

  // An empty accumulator ignores the flush and lets arbitration proceed.
  assign flush_take = i_flush && (cnt != '0);

  // This shift left-justifies a partial word. It is never WIDTH, because
  // the flush is only taken when cnt > 0.
  assign pad_shift  = WIDTH_C - cnt;

  // Round-robin pick. The search starts at ptr and wraps modulo 3.
  always_comb begin : arb_pick
    gnt_any = 1'b0;
    gnt_sel = 2'd0;
    case (ptr)
      2'd1: begin
        if (elig[1])      begin gnt_any = 1'b1; gnt_sel = 2'd1; end
        else if (elig[2]) begin gnt_any = 1'b1; gnt_sel = 2'd2; end
        else if (elig[0]) begin gnt_any = 1'b1; gnt_sel = 2'd0; end
      end
      2'd2: begin
        if (elig[2])      begin gnt_any = 1'b1; gnt_sel = 2'd2; end
        else if (elig[0]) begin gnt_any = 1'b1; gnt_sel = 2'd0; end
        else if (elig[1]) begin gnt_any = 1'b1; gnt_sel = 2'd1; end
      end
      default: begin
        if (elig[0])      begin gnt_any = 1'b1; gnt_sel = 2'd0; end
        else if (elig[1]) begin gnt_any = 1'b1; gnt_sel = 2'd1; end
        else if (elig[2]) begin gnt_any = 1'b1; gnt_sel = 2'd2; end
      end
    endcase
  end

  // FSM next-state, datapath next-values and grant output.
  always_comb begin : fsm_next
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ptr_n   = ptr;
    o_ready = 3'b000;
    case (state)
      COLLECT: begin
        if (flush_take) begin
          // A flush blocks every grant in its cycle.
          acc_n   = acc << pad_shift;
          state_n = EMIT;
        end else if (gnt_any) begin
          o_ready = 3'b001 << gnt_sel;
          case (gnt_sel)
            2'd1: begin
              acc_n = (acc << 8) | WIDTH'({8{b1}});
              cnt_n = sum1[CW-1:0];
              ptr_n = 2'd2;
              if (sum1 == WIDTH_W) state_n = EMIT;
            end
            2'd2: begin
              acc_n = (acc << 16) | WIDTH'({16{b2}});
              cnt_n = sum2[CW-1:0];
              ptr_n = 2'd0;
              if (sum2 == WIDTH_W) state_n = EMIT;
            end
            default: begin
              acc_n = (acc << 1) | WIDTH'(b0);
              cnt_n = sum0[CW-1:0];
              ptr_n = 2'd1;
              if (sum0 == WIDTH_W) state_n = EMIT;
            end
          endcase
        end
      end
      EMIT: begin
        // ptr is preserved, so arbitration resumes where it left off.
        if (i_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= COLLECT;
      acc   <= '0;
      cnt   <= '0;
      ptr   <= 2'd0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  assign o_valid     = (state == EMIT);
  assign o_data      = acc;
  assign o_fill      = cnt;
  assign o_dbg_state = state;

`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
  logic [15:0] word_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_count <= 16'd0;
    end else if (o_valid && i_ready) begin
      word_count <= word_count + 16'd1;
    end
  end

  assign o_word_count = word_count;
`endif

endmodule

// File: tb/tb_replicate_pack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_replicate_pack_arbiter
//
// Self-checking bench for replicate_pack_arbiter (WIDTH = 32).
//
// Timing: inputs are driven just after the falling edge, and outputs are
// sampled 1 ns later, well clear of the rising edge.
//
// Reference model: the accumulator is a queue of bits in acceptance order.
// The o_data value expected in COLLECT is that queue read as a right-aligned
// number. In EMIT it is the same queue left-aligned in a WIDTH-bit word.
// ---------------------------------------------------------------------------
module tb_replicate_pack_arbiter;

  localparam int WIDTH = 32;
  localparam int IW    = $clog2(WIDTH);

  // clock / reset
  logic              i_clk;
  logic              i_rst_n;
  logic [2:0]        i_valid;
  logic [2:0]        o_ready;
  logic [WIDTH-1:0]  i_data0, i_data1, i_data2;
  logic [IW-1:0]     i_idx0, i_idx1, i_idx2;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [WIDTH-1:0]  o_data;
  logic [IW:0]       o_fill;
  logic              o_dbg_state;
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
  logic [15:0]       o_word_count;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  replicate_pack_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data0     (i_data0),
    .i_data1     (i_data1),
    .i_data2     (i_data2),
    .i_idx0      (i_idx0),
    .i_idx1      (i_idx1),
    .i_idx2      (i_idx2),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_fill      (o_fill),
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
    .o_word_count(o_word_count),
`endif
    .o_dbg_state (o_dbg_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // behavioural reference model
  logic m_bits[$];
  bit   m_emit;
  int   m_ptr;
  int   m_wc;

  function automatic int rep_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 16;
  endfunction

  function automatic logic sel_bit(input int k);
    if (k == 0) return i_data0[i_idx0];
    if (k == 1) return i_data1[i_idx1];
    return i_data2[i_idx2];
  endfunction

  // Returns the requester granted this cycle, or -1 when there is no grant.
  function automatic int model_grant();
    int k;
    if (m_emit) return -1;
    if (i_flush && m_bits.size() > 0) return -1;
    for (int j = 0; j < 3; j++) begin
      k = (m_ptr + j) % 3;
      if (i_valid[k] && (m_bits.size() + rep_of(k) <= WIDTH)) return k;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] model_word();
    logic [WIDTH-1:0] w;
    int n;
    w = '0;
    n = m_bits.size();
    for (int i = 0; i < n; i++) begin
      if (m_emit) w[WIDTH-1-i] = m_bits[i];
      else        w[n-1-i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_emit = 1'b0;
    m_ptr  = 0;
    m_wc   = 0;
  endtask

  // Compares every output with the model, then advances the model one edge.
  task automatic model_step();
    int g;
    logic [2:0] exp_ready;
    logic b;
    g = model_grant();
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("model.o_ready", 64'(o_ready), 64'(exp_ready));
    check("model.o_valid", 64'(o_valid), 64'(m_emit));
    check("model.o_fill",  64'(o_fill),  64'(m_bits.size()));
    check("model.o_data",  64'(o_data),  64'(model_word()));
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
    check("model.o_word_count", 64'(o_word_count), 64'(m_wc % 65536));
`endif
    if (m_emit) begin
      if (i_ready) begin
        m_bits.delete();
        m_emit = 1'b0;
        m_wc   = m_wc + 1;
      end
    end else if (i_flush && m_bits.size() > 0) begin
      m_emit = 1'b1;
    end else if (g >= 0) begin
      b = sel_bit(g);
      for (int i = 0; i < rep_of(g); i++) m_bits.push_back(b);
      m_ptr = (g + 1) % 3;
      if (m_bits.size() == WIDTH) m_emit = 1'b1;
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [2:0] v, input logic f, input logic r);
    i_valid = v;
    i_flush = f;
    i_ready = r;
  endtask

  // Called just after a falling edge with the inputs already applied.
  task automatic tick();
    #1;
    model_step();
    @(negedge i_clk);
  endtask

  // stimulus table
  typedef struct {
    logic [2:0]       valid;
    logic             flush;
    logic             ready;
    logic [2:0]       exp_ready;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [IW:0]      exp_fill;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [2:0] v, input logic f,
                              input logic r, input logic [2:0] er,
                              input logic ev, input logic [WIDTH-1:0] ed,
                              input int ef);
    vec_t t;
    t.valid     = v;
    t.flush     = f;
    t.ready     = r;
    t.exp_ready = er;
    t.exp_valid = ev;
    t.exp_data  = ed;
    t.exp_fill  = (IW+1)'(ef);
    return t;
  endfunction

  initial begin
    // Round robin with all requesters valid: bit values 1, 0, 1.
    tbl[0]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h0000_0000, 0);
    tbl[1]  = mk(3'b111, 0, 0, 3'b010, 0, 32'h0000_0001, 1);
    tbl[2]  = mk(3'b111, 0, 0, 3'b100, 0, 32'h0000_0100, 9);
    tbl[3]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h0100_FFFF, 25);
    tbl[4]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h0201_FFFF, 26);
    tbl[5]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h0403_FFFF, 27);
    tbl[6]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h0807_FFFF, 28);
    tbl[7]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h100F_FFFF, 29);
    tbl[8]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h201F_FFFF, 30);
    tbl[9]  = mk(3'b111, 0, 0, 3'b001, 0, 32'h403F_FFFF, 31);
    tbl[10] = mk(3'b111, 0, 1, 3'b000, 1, 32'h807F_FFFF, 32);
    tbl[11] = mk(3'b000, 0, 1, 3'b000, 0, 32'h0000_0000, 0);

    model_reset();
    i_rst_n = 1'b0;
    set_in(3'b000, 1'b0, 1'b0);
    i_data0 = '0; i_data1 = '0; i_data2 = '0;
    i_idx0  = '0; i_idx1  = '0; i_idx2  = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("reset.o_valid", 64'(o_valid), 64'd0);
    check("reset.o_data",  64'(o_data),  64'd0);
    check("reset.o_fill",  64'(o_fill),  64'd0);
    check("reset.o_ready", 64'(o_ready), 64'd0);
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
    check("reset.o_word_count", 64'(o_word_count), 64'd0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Table-driven round robin.
    i_data0 = 32'h1; i_idx0 = 5'd0;
    i_data1 = 32'h0; i_idx1 = 5'd1;
    i_data2 = 32'h4; i_idx2 = 5'd2;
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].valid, tbl[i].flush, tbl[i].ready);
      #1;
      check($sformatf("rr%0d.o_ready", i), 64'(o_ready), 64'(tbl[i].exp_ready));
      check($sformatf("rr%0d.o_valid", i), 64'(o_valid), 64'(tbl[i].exp_valid));
      check($sformatf("rr%0d.o_data", i),  64'(o_data),  64'(tbl[i].exp_data));
      check($sformatf("rr%0d.o_fill", i),  64'(o_fill),  64'(tbl[i].exp_fill));
      tick();
    end

    // Single requester with the 16x factor: two grants, then a full word.
    set_in(3'b100, 0, 0);
    tick();
    tick();
    set_in(3'b000, 0, 0);
    #1;
    check("single.o_valid", 64'(o_valid), 64'd1);
    check("single.o_data",  64'(o_data),  64'hFFFF_FFFF);
    check("single.o_fill",  64'(o_fill),  64'd32);
    tick();
    set_in(3'b000, 0, 1);
    tick();

    // Flush after one requester-1 grant with bit value 1.
    i_data1 = 32'h2;
    set_in(3'b010, 0, 0);
    tick();
    set_in(3'b000, 1, 0);
    tick();
    set_in(3'b000, 0, 0);
    #1;
    check("flush.o_valid", 64'(o_valid), 64'd1);
    check("flush.o_data",  64'(o_data),  64'hFF00_0000);
    check("flush.o_fill",  64'(o_fill),  64'd8);
    tick();
    set_in(3'b000, 0, 1);
    tick();

    // Backpressure: the word is held and no grants occur while i_ready is 0.
    // ptr is 2 at this point.
    set_in(3'b100, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(3'b111, 0, 0);
      #1;
      check($sformatf("bp%0d.o_ready", i), 64'(o_ready), 64'd0);
      check($sformatf("bp%0d.o_data", i),  64'(o_data),  64'hFFFF_FFFF);
      check($sformatf("bp%0d.o_fill", i),  64'(o_fill),  64'd32);
      tick();
    end
    set_in(3'b111, 0, 1);
    tick();
    set_in(3'b111, 0, 0);
    #1;
    check("bp.resume_grant", 64'(o_ready), 64'b001);
    tick();

    // Overflow stall at cnt=24. Clean up first with a flush and a handshake.
    set_in(3'b000, 1, 0);
    tick();
    set_in(3'b000, 0, 1);
    tick();
    i_data1 = 32'h0;
    i_data2 = 32'h4;
    set_in(3'b010, 0, 0);
    tick();
    set_in(3'b100, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(3'b100, 0, 0);
      #1;
      check($sformatf("stall%0d.o_ready", i), 64'(o_ready), 64'd0);
      check($sformatf("stall%0d.o_fill", i),  64'(o_fill),  64'd24);
      tick();
    end
    set_in(3'b100, 1, 0);
    tick();
    set_in(3'b000, 0, 0);
    #1;
    check("stall.flush_data", 64'(o_data), 64'h00FF_FF00);
    check("stall.flush_fill", 64'(o_fill), 64'd24);
    tick();
    set_in(3'b000, 0, 1);
    tick();

    // Reset mid-word at cnt=9.
    i_data0 = 32'h1;
    set_in(3'b001, 0, 0);
    tick();
    set_in(3'b010, 0, 0);
    tick();
    set_in(3'b000, 0, 0);
    #1;
    check("rst.pre_fill", 64'(o_fill), 64'd9);
    i_rst_n = 1'b0;
    #1;
    check("rst.o_fill",  64'(o_fill),  64'd0);
    check("rst.o_valid", 64'(o_valid), 64'd0);
    check("rst.o_data",  64'(o_data),  64'd0);
`ifdef REPLICATE_PACK_ARBITER_WORD_COUNT_EN
    check("rst.o_word_count", 64'(o_word_count), 64'd0);
`endif
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    set_in(3'b100, 0, 0);
    tick();
    tick();
    set_in(3'b000, 0, 0);
    #1;
    check("rst.after_data", 64'(o_data), 64'hFFFF_FFFF);
    check("rst.after_fill", 64'(o_fill), 64'd32);
    set_in(3'b000, 0, 1);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      i_data0 = $urandom();
      i_data1 = $urandom();
      i_data2 = $urandom();
      i_idx0  = IW'($urandom_range(0, WIDTH-1));
      i_idx1  = IW'($urandom_range(0, WIDTH-1));
      i_idx2  = IW'($urandom_range(0, WIDTH-1));
      set_in(3'($urandom_range(0, 7)),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
